// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I core constants and encodings
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int ALUC_W = 4;

  // Architectural zero register; writes to it are discarded, so it never bypasses.
  localparam logic [4:0] X0_IDX = 5'd0;

  typedef enum logic [1:0] {
    RES_SRC_ALU = 2'b00,
    RES_SRC_MEM = 2'b01,
    RES_SRC_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_t;

endpackage

// File: rtl/wb_bypass.sv
// rtl/wb_bypass.sv - writeback-to-operand bypass select
//
// Ports:
//   src_idx     source register index being read
//   data_in     candidate operand (register file or held E-stage value)
//   reg_write_w writeback write enable
//   rd_w        writeback destination index
//   result_w    writeback data
//   data_out    result_w when writeback targets src_idx (and it is not x0), else data_in
module wb_bypass
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [4:0]      src_idx,
  input  logic [XLEN-1:0] data_in,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] data_out
);

  logic hit;

  assign hit      = reg_write_w && (rd_w != X0_IDX) && (rd_w == src_idx);
  assign data_out = hit ? result_w : data_in;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - decode-to-execute pipeline register with writeback bypass
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stall_e, flush_e         hold the stage / load a bubble (flush wins)
//   *_d                      decode-stage operands, indices, PCs, immediate, control
//   reg_write_w, rd_w,
//   result_w                 writeback port, bypassed into the captured operands
//   valid_e, *_e             execute-stage registered copies
module id_ex_pipe_reg
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int ALUC_W = riscv_pkg::ALUC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pcplus4_d,
  input  logic [XLEN-1:0]   imm_ext_d,
  input  logic              reg_write_d,
  input  logic              mem_write_d,
  input  logic              jump_d,
  input  logic              branch_d,
  input  logic              alu_src_d,
  input  logic [1:0]        result_src_d,
  input  logic [ALUC_W-1:0] alu_control_d,
  input  logic              reg_write_w,
  input  logic [4:0]        rd_w,
  input  logic [XLEN-1:0]   result_w,
  output logic              valid_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pcplus4_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic              reg_write_e,
  output logic              mem_write_e,
  output logic              jump_e,
  output logic              branch_e,
  output logic              alu_src_e,
  output logic [1:0]        result_src_e,
  output logic [ALUC_W-1:0] alu_control_e
);

  logic [XLEN-1:0] rd1_load, rd2_load;
  logic [XLEN-1:0] rd1_hold, rd2_hold;

  // The register file reads the old value in the cycle it is written, so the
  // operands are patched with result_w on the way in.
  wb_bypass #(.XLEN(XLEN)) u_byp_rs1_load (
    .src_idx(rs1_d), .data_in(rd1_d), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .data_out(rd1_load)
  );

  wb_bypass #(.XLEN(XLEN)) u_byp_rs2_load (
    .src_idx(rs2_d), .data_in(rd2_d), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .data_out(rd2_load)
  );

  // A stalled instruction keeps watching writeback so it never executes with a
  // stale operand once released.
  wb_bypass #(.XLEN(XLEN)) u_byp_rs1_hold (
    .src_idx(rs1_e), .data_in(rd1_e), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .data_out(rd1_hold)
  );

  wb_bypass #(.XLEN(XLEN)) u_byp_rs2_hold (
    .src_idx(rs2_e), .data_in(rd2_e), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .data_out(rd2_hold)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e       <= 1'b0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      pc_e          <= '0;
      pcplus4_e     <= '0;
      imm_ext_e     <= '0;
      rs1_e         <= X0_IDX;
      rs2_e         <= X0_IDX;
      rd_e          <= X0_IDX;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      jump_e        <= 1'b0;
      branch_e      <= 1'b0;
      alu_src_e     <= 1'b0;
      result_src_e  <= RES_SRC_ALU;
      alu_control_e <= '0;
    end else if (flush_e) begin
      valid_e       <= 1'b0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      pc_e          <= '0;
      pcplus4_e     <= '0;
      imm_ext_e     <= '0;
      rs1_e         <= X0_IDX;
      rs2_e         <= X0_IDX;
      rd_e          <= X0_IDX;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      jump_e        <= 1'b0;
      branch_e      <= 1'b0;
      alu_src_e     <= 1'b0;
      result_src_e  <= RES_SRC_ALU;
      alu_control_e <= '0;
    end else if (stall_e) begin
      rd1_e <= rd1_hold;
      rd2_e <= rd2_hold;
    end else begin
      valid_e       <= 1'b1;
      rd1_e         <= rd1_load;
      rd2_e         <= rd2_load;
      pc_e          <= pc_d;
      pcplus4_e     <= pcplus4_d;
      imm_ext_e     <= imm_ext_d;
      rs1_e         <= rs1_d;
      rs2_e         <= rs2_d;
      rd_e          <= rd_d;
      reg_write_e   <= reg_write_d;
      mem_write_e   <= mem_write_d;
      jump_e        <= jump_d;
      branch_e      <= branch_d;
      alu_src_e     <= alu_src_d;
      result_src_e  <= result_src_d;
      alu_control_e <= alu_control_d;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  localparam int XLEN   = 32;
  localparam int ALUC_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              stall_e, flush_e;
  logic [XLEN-1:0]   rd1_d, rd2_d, pc_d, pcplus4_d, imm_ext_d;
  logic [4:0]        rs1_d, rs2_d, rd_d;
  logic              reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]        result_src_d;
  logic [ALUC_W-1:0] alu_control_d;
  logic              reg_write_w;
  logic [4:0]        rd_w;
  logic [XLEN-1:0]   result_w;
  logic              valid_e;
  logic [XLEN-1:0]   rd1_e, rd2_e, pc_e, pcplus4_e, imm_ext_e;
  logic [4:0]        rs1_e, rs2_e, rd_e;
  logic              reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]        result_src_e;
  logic [ALUC_W-1:0] alu_control_e;

  id_ex_pipe_reg #(.XLEN(XLEN), .ALUC_W(ALUC_W)) dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .pc_d(pc_d), .pcplus4_d(pcplus4_d), .imm_ext_d(imm_ext_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .jump_d(jump_d),
    .branch_d(branch_d), .alu_src_d(alu_src_d), .result_src_d(result_src_d),
    .alu_control_d(alu_control_d), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .valid_e(valid_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .pc_e(pc_e), .pcplus4_e(pcplus4_e), .imm_ext_e(imm_ext_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
    .alu_src_e(alu_src_e), .result_src_e(result_src_e),
    .alu_control_e(alu_control_e)
  );

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   rd1, rd2, pc, pcp4, imm;
    logic [4:0]        rs1, rs2, rd;
    logic              rw, mw, j, b, as;
    logic [1:0]        rsrc;
    logic [ALUC_W-1:0] alu;
  } e_t;

  e_t act;
  assign act = {valid_e, rd1_e, rd2_e, pc_e, pcplus4_e, imm_ext_e, rs1_e, rs2_e, rd_e,
                reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
                result_src_e, alu_control_e};

  // Architectural register file as the decode stage sees it, and the E-stage
  // contents an ideal pipeline would hold.
  logic [XLEN-1:0] regs [32];
  e_t mdl;
  e_t exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  function automatic void check(string name, e_t a, e_t e);
    chk_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, a, e);
  endfunction

  // Monitor: every edge the DUT presents a new E-stage value; compare it with
  // the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check("e_stage", act, exp_q.pop_front());
    end
  end

  // Called at negedge with all inputs except rd1_d/rd2_d set. The register file
  // returns the pre-write value; the ideal E-stage operand is the post-write
  // value of the register it names.
  task automatic step();
    e_t nx;
    logic [XLEN-1:0] rn [32];
    rd1_d = regs[rs1_d];
    rd2_d = regs[rs2_d];
    rn = regs;
    if (reg_write_w && rd_w != 5'd0) rn[rd_w] = result_w;
    if (flush_e) begin
      nx = '0;
    end else if (stall_e) begin
      nx     = mdl;
      nx.rd1 = rn[mdl.rs1];
      nx.rd2 = rn[mdl.rs2];
    end else begin
      nx = {1'b1, rn[rs1_d], rn[rs2_d], pc_d, pcplus4_d, imm_ext_d, rs1_d, rs2_d, rd_d,
            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d,
            result_src_d, alu_control_d};
    end
    regs = rn;
    mdl  = nx;
    exp_q.push_back(nx);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_d();
    rs1_d         = 5'($urandom_range(0, 7));
    rs2_d         = 5'($urandom_range(0, 7));
    rd_d          = 5'($urandom);
    pc_d          = $urandom;
    pcplus4_d     = pc_d + 32'd4;
    imm_ext_d     = $urandom;
    reg_write_d   = 1'($urandom);
    mem_write_d   = 1'($urandom);
    jump_d        = 1'($urandom);
    branch_d      = 1'($urandom);
    alu_src_d     = 1'($urandom);
    result_src_d  = 2'($urandom_range(0, 2));
    alu_control_d = 4'($urandom_range(0, 9));
  endtask

  task automatic rand_w();
    reg_write_w = 1'($urandom);
    rd_w        = 5'($urandom_range(0, 7));
    result_w    = $urandom;
  endtask

  initial begin
    rst = 1'b0;
    stall_e = 1'b0; flush_e = 1'b0;
    rd1_d = '0; rd2_d = '0; rs1_d = '0; rs2_d = '0; rd_d = '0;
    pc_d = '0; pcplus4_d = '0; imm_ext_d = '0;
    reg_write_d = 0; mem_write_d = 0; jump_d = 0; branch_d = 0; alu_src_d = 0;
    result_src_d = '0; alu_control_d = '0;
    reg_write_w = 0; rd_w = '0; result_w = '0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = '0;
    regs[1] = 32'd4;
    regs[2] = 32'd2;
    regs[3] = 32'h77;
    regs[5] = 32'd8;
    regs[6] = 32'h1234;
    mdl = '0;

    repeat (2) @(negedge clk);
    check("reset_state", act, '0);

    // First load after reset release.
    rst = 1'b1;
    rs1_d = 5'd1; rs2_d = 5'd2; rd_d = 5'd9; pc_d = 32'h100; pcplus4_d = 32'h104;
    imm_ext_d = 32'h10; reg_write_d = 1'b1;
    step();

    // Same-cycle bypass into rs1.
    rs1_d = 5'd5; rs2_d = 5'd1; pc_d = 32'h104; pcplus4_d = 32'h108;
    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'hDEAD;
    step();

    // Writeback to x0 must not bypass.
    rs1_d = 5'd2; rs2_d = 5'd0; rd_w = 5'd0; result_w = 32'hFFFF;
    step();

    // Hold an instruction reading x3; writeback updates x3 in the 2nd stalled cycle.
    rs1_d = 5'd3; rs2_d = 5'd1; pc_d = 32'h200; reg_write_w = 1'b0;
    step();
    stall_e = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_d();
      reg_write_w = (k == 1);
      rd_w        = 5'd3;
      result_w    = 32'h55;
      step();
    end
    stall_e = 1'b0; reg_write_w = 1'b0;

    // Flush beats stall, then a plain load.
    flush_e = 1'b1; stall_e = 1'b1; rand_d();
    step();
    flush_e = 1'b0; stall_e = 1'b0; rand_d();
    step();

    // Asynchronous reset while stalled.
    rand_d(); rs1_d = 5'd6;
    step();
    stall_e = 1'b1;
    step();
    #2 rst = 1'b0;
    #1 check("async_reset", act, '0);
    mdl = '0;
    @(posedge clk);
    #1 check("reset_over_stall", act, '0);
    @(negedge clk);
    rst = 1'b1; stall_e = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      rand_d();
      rand_w();
      flush_e = ($urandom_range(0, 9) == 0);
      stall_e = ($urandom_range(0, 3) == 0);
      step();
    end
    stall_e = 1'b0; flush_e = 1'b0;

    @(posedge clk);
    #2;
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d outstanding, required 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
